// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Program-counter / fetch stage sitting directly upstream of the control
//   decoder. It owns the PC, which is also the instruction-memory address.
//   It resolves jumps and conditional branches from the decoder strobes and the
//   compare flags. Branch and jump targets come from a small internal target
//   LUT, indexed by the low instruction bits. A start/done handshake and a
//   saturating cycle counter are provided for the test harness.
//
// Ports
//   clk        in   1        clock; all state changes on the rising edge
//   reset      in   1        asynchronous, active-high reset
//   start      in   1        level; begins a run from PC 0 when IDLE or HALTED
//   instr      in   INSTR_W  instruction at address pc (combinational imem)
//   branch_en  in   1        conditional branch strobe from the decoder
//   jump_en    in   1        unconditional jump strobe from the decoder
//   cond       in   2        branch condition: 00 lt, 01 gt, 10 ne, 11 eq
//   flag_lt    in   1        last compare: op1 < op2
//   flag_gt    in   1        last compare: op1 > op2
//   flag_eq    in   1        last compare: op1 == op2
//   lut_we     in   1        target LUT write enable
//   lut_waddr  in   LUT_AW   target LUT write index
//   lut_wdata  in   PC_W     target LUT write data
//   pc         out  PC_W     current PC (imem address)
//   running    out  1        high while in RUN
//   done       out  1        high while in HALTED
//   taken      out  1        high for the cycle after a redirect
//   cycle_cnt  out  CNT_W    RUN cycles since the last start, saturating
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int                   PC_W       = 10,
   parameter int                   INSTR_W    = 9,
   parameter int                   LUT_AW     = 5,
   parameter int                   CNT_W      = 16,
   parameter logic [INSTR_W-1:0]   HALT_INSTR = 9'h1FF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [INSTR_W-1:0] instr,
   input  logic               branch_en,
   input  logic               jump_en,
   input  logic [1:0]         cond,
   input  logic               flag_lt,
   input  logic               flag_gt,
   input  logic               flag_eq,
   input  logic               lut_we,
   input  logic [LUT_AW-1:0]  lut_waddr,
   input  logic [PC_W-1:0]    lut_wdata,
   output logic [PC_W-1:0]    pc,
   output logic               running,
   output logic               done,
   output logic               taken,
   output logic [CNT_W-1:0]   cycle_cnt
);

   localparam int             LUT_DEPTH = 2 ** LUT_AW;
   localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
   localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [PC_W-1:0]   pc_r;
   logic [PC_W-1:0]   pc_next_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_next_s;
   logic              taken_r;
   logic              running_r;
   logic              done_r;
   logic              redirect_s;
   logic              cond_true_s;
   logic              halt_s;
   logic [PC_W-1:0]   target_s;
   logic [PC_W-1:0]   lut_r [LUT_DEPTH];

   // The LUT read is taken from the registered array, so a write to the
   // entry being read this cycle only lands at the edge: the old target wins.
   assign target_s = lut_r[instr[LUT_AW-1:0]];
   assign halt_s   = (instr == HALT_INSTR);

   // Branch condition decode against the compare flags.
   always_comb begin
      cond_true_s = 1'b0;
      case (cond)
         2'b00:   cond_true_s = flag_lt;
         2'b01:   cond_true_s = flag_gt;
         2'b10:   cond_true_s = ~flag_eq;
         2'b11:   cond_true_s = flag_eq;
         default: cond_true_s = 1'b0;
      endcase
   end

   // Next-state, next-PC and counter logic; strobes only matter in RUN.
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = pc_r;
      cnt_next_s   = cnt_r;
      redirect_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_RUN;
               pc_next_s    = PC_ZERO;
               cnt_next_s   = CNT_ZERO;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // The halt cycle itself is a RUN cycle and is counted.
            if (cnt_r != CNT_MAX) begin
               cnt_next_s = cnt_r + CNT_ONE;
            end else begin
               cnt_next_s = CNT_MAX;
            end
            if (halt_s) begin
               state_next_s = ST_HALTED;
               pc_next_s    = pc_r;
            end else if (jump_en || (branch_en && cond_true_s)) begin
               redirect_s = 1'b1;
               pc_next_s  = target_s;
            end else begin
               pc_next_s = pc_r + PC_ONE;
            end
         end
         ST_HALTED: begin
            if (start) begin
               state_next_s = ST_RUN;
               pc_next_s    = PC_ZERO;
               cnt_next_s   = CNT_ZERO;
            end else begin
               state_next_s = ST_HALTED;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            pc_next_s    = PC_ZERO;
            cnt_next_s   = CNT_ZERO;
         end
      endcase
   end

   // FSM, PC, counter and status flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pc_r      <= PC_ZERO;
         cnt_r     <= CNT_ZERO;
         taken_r   <= 1'b0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         pc_r      <= pc_next_s;
         cnt_r     <= cnt_next_s;
         taken_r   <= redirect_s;
         running_r <= (state_next_s == ST_RUN);
         done_r    <= (state_next_s == ST_HALTED);
      end
   end

   // Target LUT storage; writable in any state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_r[i] <= PC_ZERO;
         end
      end else if (lut_we) begin
         lut_r[lut_waddr] <= lut_wdata;
      end
   end

   assign pc        = pc_r;
   assign running   = running_r;
   assign done      = done_r;
   assign taken     = taken_r;
   assign cycle_cnt = cnt_r;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. The stimulus process plays the role of
//   instruction memory and decoder. For every clock it drives, it queues the
//   hand-computed outputs expected after that edge. A monitor pops one entry at
//   each falling edge, or just after an asynchronous reset assertion, and
//   compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [8:0] NOP  = 9'h000;
   localparam logic [8:0] HALT = 9'h1FF;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [8:0] instr = 9'h000;
   logic       branch_en = 1'b0;
   logic       jump_en = 1'b0;
   logic [1:0] cond = 2'b00;
   logic       flag_lt = 1'b0;
   logic       flag_gt = 1'b0;
   logic       flag_eq = 1'b0;
   logic       lut_we = 1'b0;
   logic [4:0] lut_waddr = 5'd0;
   logic [9:0] lut_wdata = 10'd0;
   logic [9:0] pc;
   logic       running;
   logic       done;
   logic       taken;
   logic [15:0] cycle_cnt;

   typedef struct {
      int          id;
      logic [9:0]  pc;
      logic        taken;
      logic        running;
      logic        done;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   instr_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .instr     (instr),
      .branch_en (branch_en),
      .jump_en   (jump_en),
      .cond      (cond),
      .flag_lt   (flag_lt),
      .flag_gt   (flag_gt),
      .flag_eq   (flag_eq),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
      .pc        (pc),
      .running   (running),
      .done      (done),
      .taken     (taken),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   // Monitor: one expectation per falling edge, or right after async reset.
   always begin
      @(negedge clk or posedge reset);
      if (reset) #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (pc !== e.pc || taken !== e.taken || running !== e.running ||
             done !== e.done || cycle_cnt !== e.cnt) begin
            errors++;
            $display("FAIL step%0d: got pc=%h taken=%b running=%b done=%b cnt=%0d, want pc=%h taken=%b running=%b done=%b cnt=%0d",
                     e.id, pc, taken, running, done, cycle_cnt,
                     e.pc, e.taken, e.running, e.done, e.cnt);
         end
      end
   end

   // Start a new cycle: wait past the falling edge and return inputs to idle values.
   task automatic nxt();
      @(negedge clk);
      #1;
      start     = 1'b0;
      instr     = NOP;
      branch_en = 1'b0;
      jump_en   = 1'b0;
      cond      = 2'b00;
      flag_lt   = 1'b0;
      flag_gt   = 1'b0;
      flag_eq   = 1'b0;
      lut_we    = 1'b0;
      lut_waddr = 5'd0;
      lut_wdata = 10'd0;
   endtask

   // Queue the outputs expected after the coming edge (or async event).
   task automatic expect_out(input logic [9:0] p, input logic t, input logic r,
                             input logic d, input logic [15:0] c);
      exp_t e;
      step_id++;
      e.id = step_id; e.pc = p; e.taken = t; e.running = r; e.done = d; e.cnt = c;
      q.push_back(e);
   endtask

   function automatic logic [8:0] bi(input logic [1:0] c, input logic [4:0] idx);
      return {2'b00, c, idx};
   endfunction

   task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
      nxt();
      lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
      expect_out(10'h003, 1'b0, 1'b0, 1'b1, 16'd4);
   endtask

   initial begin
      // Branch table: cond, lt, gt, eq, branch_en, expected pc, expected taken
      logic [1:0] bc [9] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
      logic       bl [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       bg [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       be [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       bb [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [9:0] bp [9] = '{10'h042, 10'h100, 10'h101, 10'h100, 10'h101,
                             10'h100, 10'h101, 10'h100, 10'h101};
      logic       bt [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state while reset is held, then IDLE after release.
      nxt(); expect_out(10'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      nxt(); reset = 1'b0; expect_out(10'h000, 1'b0, 1'b0, 1'b0, 16'd0);

      // Three nops then HALT at address 3.
      nxt(); start = 1'b1; expect_out(10'h000, 1'b0, 1'b1, 1'b0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         nxt(); expect_out(10'(i + 1), 1'b0, 1'b1, 1'b0, 16'(i + 1));
      end
      nxt(); instr = HALT; expect_out(10'h003, 1'b0, 1'b0, 1'b1, 16'd4);
      // Strobes are ignored while HALTED.
      nxt(); instr = bi(2'b00, 5'd5); jump_en = 1'b1;
      expect_out(10'h003, 1'b0, 1'b0, 1'b1, 16'd4);

      // LUT programming in HALTED.
      lut_write(5'd5, 10'h040);
      lut_write(5'd6, 10'h100);
      lut_write(5'd7, 10'h3FF);
      lut_write(5'd8, 10'h0AA);

      // Restart clears pc and counter; run to pc 7 and jump through lut[5].
      nxt(); start = 1'b1; expect_out(10'h000, 1'b0, 1'b1, 1'b0, 16'd0);
      for (int i = 0; i < 7; i++) begin
         nxt(); expect_out(10'(i + 1), 1'b0, 1'b1, 1'b0, 16'(i + 1));
      end
      nxt(); jump_en = 1'b1; instr = bi(2'b00, 5'd5);
      expect_out(10'h040, 1'b1, 1'b1, 1'b0, 16'd8);
      nxt(); expect_out(10'h041, 1'b0, 1'b1, 1'b0, 16'd9);

      // Branch conditions, matching and non-matching flags, target lut[6].
      for (int i = 0; i < 9; i++) begin
         nxt();
         cond = bc[i]; flag_lt = bl[i]; flag_gt = bg[i]; flag_eq = be[i];
         branch_en = bb[i]; instr = bi(bc[i], 5'd6);
         expect_out(bp[i], bt[i], 1'b1, 1'b0, 16'(10 + i));
      end

      // Jump wins over a branch whose condition is false.
      nxt(); jump_en = 1'b1; branch_en = 1'b1; cond = 2'b11; flag_eq = 1'b0;
      instr = bi(2'b11, 5'd5);
      expect_out(10'h040, 1'b1, 1'b1, 1'b0, 16'd19);
      // Same-cycle write to the entry being read: the old target is used.
      nxt(); jump_en = 1'b1; instr = bi(2'b00, 5'd8);
      lut_we = 1'b1; lut_waddr = 5'd8; lut_wdata = 10'h155;
      expect_out(10'h0AA, 1'b1, 1'b1, 1'b0, 16'd20);
      nxt(); jump_en = 1'b1; instr = bi(2'b00, 5'd8);
      expect_out(10'h155, 1'b1, 1'b1, 1'b0, 16'd21);

      // PC wrap from 1023 to 0.
      nxt(); jump_en = 1'b1; instr = bi(2'b00, 5'd7);
      expect_out(10'h3FF, 1'b1, 1'b1, 1'b0, 16'd22);
      nxt(); expect_out(10'h000, 1'b0, 1'b1, 1'b0, 16'd23);
      nxt(); expect_out(10'h001, 1'b0, 1'b1, 1'b0, 16'd24);
      for (int p = 1; p < 21; p++) begin
         nxt(); expect_out(10'(p + 1), 1'b0, 1'b1, 1'b0, 16'(24 + p));
      end

      // Asynchronous reset while pc = 0x15, checked before the next rising edge.
      nxt(); expect_out(10'h000, 1'b0, 1'b0, 1'b0, 16'd0); reset = 1'b1;
      nxt(); expect_out(10'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      nxt(); reset = 1'b0; expect_out(10'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      nxt(); jump_en = 1'b1; instr = bi(2'b00, 5'd5);
      expect_out(10'h000, 1'b0, 1'b0, 1'b0, 16'd0);
      nxt(); start = 1'b1; expect_out(10'h000, 1'b0, 1'b1, 1'b0, 16'd0);
      nxt(); expect_out(10'h001, 1'b0, 1'b1, 1'b0, 16'd1);
      nxt(); instr = HALT; expect_out(10'h001, 1'b0, 1'b0, 1'b1, 16'd2);
      nxt(); start = 1'b1; expect_out(10'h000, 1'b0, 1'b1, 1'b0, 16'd0);
      // start is ignored in RUN.
      nxt(); start = 1'b1; expect_out(10'h001, 1'b0, 1'b1, 1'b0, 16'd1);
      nxt(); expect_out(10'h002, 1'b0, 1'b1, 1'b0, 16'd2);

      // Counter saturation: 65540 further nop cycles with no checks, then pc = 7.
      repeat (65540) @(negedge clk);
      nxt(); expect_out(10'h007, 1'b0, 1'b1, 1'b0, 16'hFFFF);
      nxt(); expect_out(10'h008, 1'b0, 1'b1, 1'b0, 16'hFFFF);
      // Halt has priority over a jump strobe.
      nxt(); instr = HALT; jump_en = 1'b1;
      expect_out(10'h008, 1'b0, 1'b0, 1'b1, 16'hFFFF);
      nxt(); expect_out(10'h008, 1'b0, 1'b0, 1'b1, 16'hFFFF);

      @(negedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
